vector_sweep_checker: RTL and testbench

- Synthesisable successor to the hand-written three-input stimulus sequences.
- Drives every combination of an IN_W-bit DUT input bus and holds each vector for HOLD_CYCLES clocks.
- Samples the DUT's OUT_W-bit response at the end of each hold and compresses it into a MISR signature.
- One bench or on-chip BIST wrapper then checks any combinational block with a single signature compare instead of per-vector checks.

---
 rtl/vector_sweep_checker.sv | 128 ++++++++++++
 tb/tb_vector_sweep_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sweep_checker.sv
// Exhaustive input sweep with MISR response compaction.
// Drives every IN_W-bit vector (binary up, Gray, or binary down order), holds
// each for HOLD_CYCLES clocks, samples the DUT response on the last hold
// cycle and folds it into a SIG_W-bit MISR signature.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   start         begin a sweep (accepted in IDLE or DONE only)
//   mode          order, latched at start: 0 up, 1 Gray, 2 down, 3 as 0
//   vec_out       vector driven to the DUT inputs
//   resp_in       DUT response
//   sample_strobe high during the last hold cycle of each vector
//   busy          sweep in progress
//   done          sweep complete, signature valid
//   vec_count     vectors sampled so far
//   signature     MISR contents
module vector_sweep_checker #(
    parameter int unsigned IN_W        = 3,
    parameter int unsigned OUT_W       = 2,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [IN_W-1:0]  vec_out,
    input  logic [OUT_W-1:0] resp_in,
    output logic             sample_strobe,
    output logic             busy,
    output logic             done,
    output logic [IN_W:0]    vec_count,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IN_W-1:0]  LAST_IDX = '1;
    localparam logic             STROBE_ON_ENTRY = (HOLD_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [IN_W-1:0]  index;
    logic [CNT_W-1:0] hold_cnt;

    // Sweep index to driven vector for the selected order.
    function automatic logic [IN_W-1:0] map_vec(input logic [1:0] m, input logic [IN_W-1:0] i);
        case (m)
            2'd1:    return i ^ (i >> 1);
            2'd2:    return ~i;            // (2^IN_W-1)-i
            default: return i;
        endcase
    endfunction

    // One MISR step: Galois shift with POLY feedback, then fold in the response.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [OUT_W-1:0] r);
        logic [SIG_W-1:0] shifted;
        shifted = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0);
        return shifted ^ SIG_W'(r);
    endfunction

    // Sweep controller; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mode_q        <= 2'd0;
            index         <= '0;
            hold_cnt      <= '0;
            vec_out       <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            vec_count     <= '0;
            signature     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= DRIVE;
                        mode_q        <= mode;
                        index         <= '0;
                        hold_cnt      <= '0;
                        vec_out       <= map_vec(mode, '0);
                        sample_strobe <= STROBE_ON_ENTRY;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        vec_count     <= '0;
                        signature     <= '0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == LAST_CNT) begin
                        signature <= misr_step(signature, resp_in);
                        vec_count <= vec_count + (IN_W+1)'(1);
                        hold_cnt  <= '0;
                        if (index == LAST_IDX) begin
                            state         <= DONE;
                            sample_strobe <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            index         <= index + IN_W'(1);
                            vec_out       <= map_vec(mode_q, index + IN_W'(1));
                            sample_strobe <= STROBE_ON_ENTRY;
                        end
                    end else begin
                        hold_cnt      <= hold_cnt + CNT_W'(1);
                        // Strobe is registered, so it is raised one edge ahead.
                        sample_strobe <= ((hold_cnt + CNT_W'(1)) == LAST_CNT);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_sweep_checker.sv
module tb_vector_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: IN_W=3, HOLD=2, response = vec[1:0]
    logic        s0_start = 1'b0;
    logic [1:0]  s0_mode  = 2'd0;
    logic [2:0]  s0_vec;
    logic [1:0]  s0_resp;
    logic        s0_strobe, s0_busy, s0_done;
    logic [3:0]  s0_cnt;
    logic [15:0] s0_sig;
    assign s0_resp = s0_vec[1:0];

    // dut1: IN_W=3, HOLD=1, response = vec[1:0]
    logic        s1_start = 1'b0;
    logic [1:0]  s1_mode  = 2'd0;
    logic [2:0]  s1_vec;
    logic [1:0]  s1_resp;
    logic        s1_strobe, s1_busy, s1_done;
    logic [3:0]  s1_cnt;
    logic [15:0] s1_sig;
    assign s1_resp = s1_vec[1:0];

    // dut2: IN_W=4, HOLD=2, response forced to 2'b11 with optional one-vector fault
    logic        s2_start = 1'b0;
    logic [1:0]  s2_mode  = 2'd0;
    logic [3:0]  s2_vec;
    logic [1:0]  s2_resp;
    logic        s2_strobe, s2_busy, s2_done;
    logic [4:0]  s2_cnt;
    logic [15:0] s2_sig;
    logic        fault_en  = 1'b0;
    logic [3:0]  fault_vec = 4'd5;
    assign s2_resp = (fault_en && s2_vec == fault_vec) ? 2'b10 : 2'b11;

    vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD_CYCLES(2), .SIG_W(16), .POLY(16'h1021)) dut0 (
        .clk(clk), .rst(rst), .start(s0_start), .mode(s0_mode), .vec_out(s0_vec),
        .resp_in(s0_resp), .sample_strobe(s0_strobe), .busy(s0_busy), .done(s0_done),
        .vec_count(s0_cnt), .signature(s0_sig));

    vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD_CYCLES(1), .SIG_W(16), .POLY(16'h1021)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .mode(s1_mode), .vec_out(s1_vec),
        .resp_in(s1_resp), .sample_strobe(s1_strobe), .busy(s1_busy), .done(s1_done),
        .vec_count(s1_cnt), .signature(s1_sig));

    vector_sweep_checker #(.IN_W(4), .OUT_W(2), .HOLD_CYCLES(2), .SIG_W(16), .POLY(16'h1021)) dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .mode(s2_mode), .vec_out(s2_vec),
        .resp_in(s2_resp), .sample_strobe(s2_strobe), .busy(s2_busy), .done(s2_done),
        .vec_count(s2_cnt), .signature(s2_sig));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sig;
        int          count;
        int          busy_cycles;
    } result_t;

    int      vec0_q[$];
    int      vec1_q[$];
    result_t res0_q[$];
    result_t res1_q[$];
    result_t res2_q[$];

    int bin_seq[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int gray_seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int down_seq[8] = '{7, 6, 5, 4, 3, 2, 1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Independent MISR reference: 2'b11 every vector except fault_at gets 2'b10.
    function automatic logic [15:0] misr_ref(input int n, input int fault_at);
        logic [15:0] s;
        logic [1:0]  r;
        s = 16'h0;
        for (int k = 0; k < n; k++) begin
            r = (k == fault_at) ? 2'b10 : 2'b11;
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
        end
        return s;
    endfunction

    // Monitor: pops expected vectors at strobes and final results when done rises.
    int   busy0 = 0, busy1 = 0, busy2 = 0;
    logic done0_q = 1'b0, done1_q = 1'b0, done2_q = 1'b0;
    always @(negedge clk) begin
        result_t r;
        if (!rst) begin
            if (s0_busy) busy0++;
            if (s1_busy) busy1++;
            if (s2_busy) busy2++;

            if (s0_strobe) begin
                if (vec0_q.size() == 0) fail_now("dut0_extra_strobe");
                else chk("dut0_vec", 32'(s0_vec), 32'(vec0_q.pop_front()));
            end
            if (s1_busy) chk("dut1_strobe_every_cycle", 32'(s1_strobe), 32'd1);
            if (s1_strobe) begin
                if (vec1_q.size() == 0) fail_now("dut1_extra_strobe");
                else chk("dut1_vec", 32'(s1_vec), 32'(vec1_q.pop_front()));
            end

            if (s0_done && !done0_q) begin
                if (res0_q.size() == 0) fail_now("dut0_unexpected_done");
                else begin
                    r = res0_q.pop_front();
                    chk("dut0_signature", 32'(s0_sig), 32'(r.sig));
                    chk("dut0_vec_count", 32'(s0_cnt), 32'(r.count));
                    chk("dut0_busy_cycles", 32'(busy0), 32'(r.busy_cycles));
                    chk("dut0_done_strobe", 32'(s0_strobe), 32'd0);
                end
                busy0 = 0;
            end
            if (s1_done && !done1_q) begin
                if (res1_q.size() == 0) fail_now("dut1_unexpected_done");
                else begin
                    r = res1_q.pop_front();
                    chk("dut1_signature", 32'(s1_sig), 32'(r.sig));
                    chk("dut1_vec_count", 32'(s1_cnt), 32'(r.count));
                    chk("dut1_busy_cycles", 32'(busy1), 32'(r.busy_cycles));
                end
                busy1 = 0;
            end
            if (s2_done && !done2_q) begin
                if (res2_q.size() == 0) fail_now("dut2_unexpected_done");
                else begin
                    r = res2_q.pop_front();
                    chk("dut2_signature", 32'(s2_sig), 32'(r.sig));
                    chk("dut2_vec_count", 32'(s2_cnt), 32'(r.count));
                    chk("dut2_busy_cycles", 32'(busy2), 32'(r.busy_cycles));
                end
                busy2 = 0;
            end
        end else begin
            busy0 = 0;
            busy1 = 0;
            busy2 = 0;
        end
        done0_q = s0_done;
        done1_q = s1_done;
        done2_q = s2_done;
    end

    task automatic push_dut0(input int seq[8], input logic [15:0] sig);
        result_t r;
        for (int i = 0; i < 8; i++) vec0_q.push_back(seq[i]);
        r.sig = sig; r.count = 8; r.busy_cycles = 16;
        res0_q.push_back(r);
    endtask

    // Start pulse; mode is then moved to 3 to prove it was latched.
    task automatic pulse0(input logic [1:0] m);
        @(posedge clk); #1;
        s0_mode = m; s0_start = 1'b1;
        @(posedge clk); #1;
        s0_start = 1'b0; s0_mode = 2'd3;
    endtask

    task automatic wait_done(input int which, input int limit);
        int n = 0;
        logic d;
        d = (which == 0) ? s0_done : (which == 1) ? s1_done : s2_done;
        while (!d && n < limit) begin
            @(posedge clk); #1;
            n++;
            d = (which == 0) ? s0_done : (which == 1) ? s1_done : s2_done;
        end
        if (!d) fail_now($sformatf("dut%0d_done_timeout", which));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        result_t r;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_vec_out", 32'(s0_vec), 32'd0);
        chk("reset_busy", 32'(s0_busy), 32'd0);
        chk("reset_done", 32'(s0_done), 32'd0);
        chk("reset_strobe", 32'(s0_strobe), 32'd0);
        chk("reset_vec_count", 32'(s0_cnt), 32'd0);
        chk("reset_signature", 32'(s0_sig), 32'd0);
        chk("reset_dut2_signature", 32'(s2_sig), 32'd0);
        rst = 1'b0;

        // Binary up sweep
        push_dut0(bin_seq, 16'h0033);
        pulse0(2'd0);
        wait_done(0, 200);
        chk("done_holds_last_vec", 32'(s0_vec), 32'd7);

        // Gray sweep
        push_dut0(gray_seq, 16'h001E);
        pulse0(2'd1);
        wait_done(0, 200);

        // Down sweep with one-cycle hold
        for (int i = 0; i < 8; i++) vec1_q.push_back(down_seq[i]);
        r.sig = 16'h0132; r.count = 8; r.busy_cycles = 8;
        res1_q.push_back(r);
        @(posedge clk); #1;
        s1_mode = 2'd2; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0; s1_mode = 2'd0;
        wait_done(1, 200);

        // MISR feedback, clean then with a single-vector fault
        r.sig = misr_ref(16, -1); r.count = 16; r.busy_cycles = 32;
        res2_q.push_back(r);
        @(posedge clk); #1;
        s2_start = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0;
        wait_done(2, 400);
        fault_en = 1'b1;
        r.sig = misr_ref(16, 5);
        res2_q.push_back(r);
        @(posedge clk); #1;
        s2_start = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0;
        wait_done(2, 400);
        fault_en = 1'b0;

        // Reset during vector 3, then a clean sweep
        push_dut0(bin_seq, 16'h0033);
        pulse0(2'd0);
        n = 0;
        while (s0_vec != 3'd3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (s0_vec != 3'd3) fail_now("wait_vector3_timeout");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_vec_out", 32'(s0_vec), 32'd0);
        chk("midrst_busy", 32'(s0_busy), 32'd0);
        chk("midrst_done", 32'(s0_done), 32'd0);
        chk("midrst_signature", 32'(s0_sig), 32'd0);
        chk("midrst_vec_count", 32'(s0_cnt), 32'd0);
        vec0_q.delete();
        res0_q.delete();
        rst = 1'b0;
        push_dut0(bin_seq, 16'h0033);
        pulse0(2'd0);
        wait_done(0, 200);

        // start pulses while busy must be ignored
        push_dut0(bin_seq, 16'h0033);
        pulse0(2'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            s0_start = 1'b1; s0_mode = 2'd2;
            @(posedge clk); #1;
            s0_start = 1'b0;
        end
        wait_done(0, 200);

        // Restart from DONE
        push_dut0(bin_seq, 16'h0033);
        @(posedge clk); #1;
        s0_mode = 2'd0; s0_start = 1'b1;
        @(posedge clk); #1;
        s0_start = 1'b0;
        chk("restart_done_low", 32'(s0_done), 32'd0);
        chk("restart_busy_high", 32'(s0_busy), 32'd1);
        chk("restart_signature_cleared", 32'(s0_sig), 32'd0);
        chk("restart_vec_count_cleared", 32'(s0_cnt), 32'd0);
        wait_done(0, 200);

        chk("dut0_queue_drained", 32'(vec0_q.size() + res0_q.size()), 32'd0);
        chk("dut1_queue_drained", 32'(vec1_q.size() + res1_q.size()), 32'd0);
        chk("dut2_queue_drained", 32'(res2_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
